// File: rtl/regs_clr_if.sv
// rtl/regs_clr_if.sv - register file access bus: write port, two read ports, clear handshake
interface regs_clr_if #(
    parameter int n    = 8,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
);
    logic          w;
    logic [n-1:0]  Wdata;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr1;
    logic [AW-1:0] raddr2;
    logic [n-1:0]  Rdata1;
    logic [n-1:0]  Rdata2;
    logic          clr;
    logic          busy;
    logic          wdrop;

    modport master (
        output w, Wdata, waddr, raddr1, raddr2, clr,
        input  Rdata1, Rdata2, busy, wdrop
    );

    modport slave (
        input  w, Wdata, waddr, raddr1, raddr2, clr,
        output Rdata1, Rdata2, busy, wdrop
    );
endinterface

// File: rtl/regs_clr.sv
// rtl/regs_clr.sv - picoMIPS register file with sequential clear engine, %0 hardwired to zero
// Optional same-cycle write-to-read bypass enabled by defining REGS_BYPASS_EN.
module regs_clr #(
    parameter int n    = 8,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic       clk,
    input  logic       reset,
    regs_clr_if.slave  bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] cnt;
    logic [AW-1:0] cnt_next;
    logic          busy_q;
    logic          busy_next;
    logic          wdrop_q;
    logic          wdrop_next;
    logic          wr_en;
    logic          zero_en;
    logic          waddr_nz;

    logic [n-1:0]  gpr [NREG];

    assign waddr_nz = (bus.waddr != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            busy_q  <= 1'b0;
            wdrop_q <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            busy_q  <= busy_next;
            wdrop_q <= wdrop_next;
        end
    end

    // Clear has priority over a same-cycle write; a write that loses reports wdrop.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        busy_next  = busy_q;
        wdrop_next = 1'b0;
        wr_en      = 1'b0;
        zero_en    = 1'b0;
        case (state)
            IDLE: begin
                wdrop_next = bus.w && bus.clr && waddr_nz;
                if (bus.clr) begin
                    state_next = CLEAR;
                    cnt_next   = AW'(1);
                    busy_next  = 1'b1;
                end else if (bus.w && waddr_nz) begin
                    wr_en = 1'b1;
                end
            end
            CLEAR: begin
                zero_en    = 1'b1;
                wdrop_next = bus.w && waddr_nz;
                cnt_next   = cnt + 1'b1;
                if (cnt == AW'(NREG - 1)) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
                cnt_next   = '0;
            end
        endcase
    end

    // gpr[0] is never targeted: the clear starts at 1 and writes to %0 are filtered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                gpr[i] <= '0;
            end
        end else if (zero_en) begin
            gpr[cnt] <= '0;
        end else if (wr_en) begin
            gpr[bus.waddr] <= bus.Wdata;
        end
    end

    logic hit1;
    logic hit2;

`ifdef REGS_BYPASS_EN
    logic fwd_ok;
    assign fwd_ok = bus.w && !busy_q && !bus.clr && waddr_nz;
    assign hit1   = fwd_ok && (bus.waddr == bus.raddr1);
    assign hit2   = fwd_ok && (bus.waddr == bus.raddr2);
`else
    assign hit1 = 1'b0;
    assign hit2 = 1'b0;
`endif

    // While the engine runs the whole file is logically flushed, whatever has been zeroed so far.
    always_comb begin
        bus.Rdata1 = '0;
        if (!busy_q && (bus.raddr1 != '0)) begin
            bus.Rdata1 = hit1 ? bus.Wdata : gpr[bus.raddr1];
        end
    end

    always_comb begin
        bus.Rdata2 = '0;
        if (!busy_q && (bus.raddr2 != '0)) begin
            bus.Rdata2 = hit2 ? bus.Wdata : gpr[bus.raddr2];
        end
    end

    assign bus.busy  = busy_q;
    assign bus.wdrop = wdrop_q;

endmodule
